// File: rtl/async_fifo_wr_ctl.sv
// Write-side control for the dual-clock FIFO: write pointer, RAM write strobe, level/full/almost-full.
// Optional sticky error flag enabled by defining ASYNC_FIFO_WR_ERR_EN.
module async_fifo_wr_ctl #(
    parameter int ADDR_W    = 4,
    parameter int AFULL_LVL = 2**ADDR_W - 2
) (
    input  logic              rst_i,
    input  logic              a_clk_i,
    input  logic              wr_i,
    input  logic [ADDR_W:0]   rd_ptr_i,
    output logic [ADDR_W:0]   wr_ptr_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic              full_o,
    output logic              afull_o,
    output logic [ADDR_W:0]   level_o,
    output logic              err_o
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0] AFULL = (ADDR_W+1)'(AFULL_LVL);

    logic [ADDR_W:0] wr_ptr_reg;
    logic [ADDR_W:0] level_reg;
    logic            full_reg;
    logic            afull_reg;

    logic            acc;
    logic [ADDR_W:0] nxt_ptr;
    logic [ADDR_W:0] lvl_next;
    logic            fault;
    logic            full_next;
    logic            afull_next;

    // The level looks ahead by the push of this cycle so full_o always
    // matches the pointer it is reported alongside.
    always_comb begin
        acc        = wr_i & ~full_reg;
        nxt_ptr    = wr_ptr_reg + {{ADDR_W{1'b0}}, acc};
        lvl_next   = nxt_ptr - rd_ptr_i;
        fault      = (lvl_next > DEPTH);
        full_next  = (lvl_next == DEPTH) | fault;
        afull_next = (lvl_next >= AFULL);
    end

    always_ff @(posedge a_clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            level_reg  <= '0;
            full_reg   <= 1'b0;
            afull_reg  <= 1'b0;
        end else begin
            wr_ptr_reg <= nxt_ptr;
            level_reg  <= lvl_next;
            full_reg   <= full_next;
            afull_reg  <= afull_next;
        end
    end

`ifdef ASYNC_FIFO_WR_ERR_EN
    logic err_reg;

    always_ff @(posedge a_clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_reg <= 1'b0;
        end else if ((wr_i & full_reg) | fault) begin
            err_reg <= 1'b1;
        end
    end

    assign err_o = err_reg;
`else
    assign err_o = 1'b0;
`endif

    assign wr_ptr_o   = wr_ptr_reg;
    assign ram_addr_o = wr_ptr_reg[ADDR_W-1:0];
    assign ram_we_o   = acc;
    assign full_o     = full_reg;
    assign afull_o    = afull_reg;
    assign level_o    = level_reg;

endmodule

// File: tb/tb_async_fifo_wr_ctl.sv
// Bench for async_fifo_wr_ctl (ADDR_W=3, AFULL_LVL=6): occupancy model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_async_fifo_wr_ctl;

`ifdef ASYNC_FIFO_WR_ERR_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr  = 1'b0;
    logic [3:0] rd  = 4'd0;
    logic [3:0] wr_ptr;
    logic [2:0] ram_addr;
    logic       ram_we;
    logic       full;
    logic       afull;
    logic [3:0] level;
    logic       err;

    int checks = 0;
    int errors = 0;

    async_fifo_wr_ctl #(.ADDR_W(3), .AFULL_LVL(6)) dut (
        .rst_i      (rst),
        .a_clk_i    (clk),
        .wr_i       (wr),
        .rd_ptr_i   (rd),
        .wr_ptr_o   (wr_ptr),
        .ram_addr_o (ram_addr),
        .ram_we_o   (ram_we),
        .full_o     (full),
        .afull_o    (afull),
        .level_o    (level),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    // Occupancy model: count accepted words modulo 16, occupancy is that count minus the read pointer.
    int m_ptr   = 0;
    int m_level = 0;
    bit m_full  = 0;
    bit m_afull = 0;
    bit m_err   = 0;

    always @(posedge clk or posedge rst) begin
        int a;
        int p;
        int l;
        if (rst) begin
            m_ptr   <= 0;
            m_level <= 0;
            m_full  <= 0;
            m_afull <= 0;
            m_err   <= 0;
        end else begin
            a = (wr && !m_full) ? 1 : 0;
            p = (m_ptr + a) % 16;
            l = (p - int'(rd) + 16) % 16;
            m_ptr   <= p;
            m_level <= l;
            m_full  <= (l >= 8);
            m_afull <= (l >= 6);
            if (ERR_EN != 0 && ((wr && m_full) || l > 8))
                m_err <= 1;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_ptr",   int'(wr_ptr),   m_ptr);
        check("model_addr",  int'(ram_addr), m_ptr % 8);
        check("model_we",    int'(ram_we),   (wr && !m_full) ? 1 : 0);
        check("model_full",  int'(full),     int'(m_full));
        check("model_afull", int'(afull),    int'(m_afull));
        check("model_level", int'(level),    m_level);
        check("model_err",   int'(err),      int'(m_err));
    end

    // Apply inputs just after an edge; they are sampled at the following edge.
    task automatic set_in(input bit w, input int r);
        wr = w;
        rd = 4'(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p;
        #1;
        check("reset_ptr",   int'(wr_ptr), 0);
        check("reset_level", int'(level),  0);
        check("reset_full",  int'(full),   0);
        check("reset_err",   int'(err),    0);
        tick();
        rst = 1'b0;

        // Fill: nine pushes into an 8-deep FIFO with rd_ptr held at 0.
        for (int i = 0; i < 9; i++) begin
            set_in(1'b1, 0);
            #1;
            check("fill_we",   int'(ram_we),   (i < 8) ? 1 : 0);
            if (i < 8) check("fill_addr", int'(ram_addr), i);
            tick();
            check("fill_afull", int'(afull), (i >= 5) ? 1 : 0);
            check("fill_full",  int'(full),  (i >= 7) ? 1 : 0);
        end
        check("fill_level", int'(level),  8);
        check("fill_ptr",   int'(wr_ptr), 8);
        check("fill_err",   int'(err),    ERR_EN);

        // Drain release: the reader has consumed three words.
        set_in(1'b0, 3);
        tick();
        check("drain_full",  int'(full),  0);
        check("drain_level", int'(level), 5);
        check("drain_afull", int'(afull), 0);
        set_in(1'b1, 3);
        #1;
        check("drain_we",   int'(ram_we),   1);
        check("drain_addr", int'(ram_addr), 0);
        tick();
        check("drain_ptr",   int'(wr_ptr), 9);
        check("drain_level2", int'(level), 6);

        // Simultaneous push and read advance at level 5.
        set_in(1'b0, 4);
        tick();
        check("simul_pre_level", int'(level), 5);
        set_in(1'b1, 5);
        tick();
        check("simul_level", int'(level),  5);
        check("simul_ptr",   int'(wr_ptr), 10);

        // Wrap: continuous pushes with the reader two words behind.
        p = 10;
        for (int k = 0; k < 8; k++) begin
            set_in(1'b1, (p + 15) % 16);
            #1;
            check("wrap_we",   int'(ram_we),   1);
            check("wrap_addr", int'(ram_addr), p % 8);
            tick();
            p = (p + 1) % 16;
            check("wrap_ptr",   int'(wr_ptr), p);
            check("wrap_level", int'(level),  2);
        end

        // Reset mid-fill at level 4, asserted between clock edges.
        rst = 1'b1;
        set_in(1'b0, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 0);
            tick();
        end
        check("rst_pre_level", int'(level), 4);
        set_in(1'b0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_ptr",   int'(wr_ptr),   0);
        check("rst_async_level", int'(level),    0);
        check("rst_async_addr",  int'(ram_addr), 0);
        check("rst_async_afull", int'(afull),    0);
        tick();
        rst = 1'b0;
        set_in(1'b1, 0);
        #1;
        check("rst_first_we",   int'(ram_we),   1);
        check("rst_first_addr", int'(ram_addr), 0);
        tick();
        set_in(1'b1, 0);
        tick();
        check("fault_pre_ptr", int'(wr_ptr), 2);

        // Pointer fault: rd_ptr jumps ahead of the write pointer.
        set_in(1'b0, 12);
        tick();
        check("fault_level6", int'(level), 6);
        check("fault_full6",  int'(full),  0);
        check("fault_afull6", int'(afull), 1);
        set_in(1'b0, 9);
        tick();
        check("fault_level9", int'(level), 9);
        check("fault_full9",  int'(full),  1);
        set_in(1'b1, 9);
        #1;
        check("fault_we", int'(ram_we), 0);
        tick();
        check("fault_ptr", int'(wr_ptr), 2);
        check("fault_err", int'(err),    ERR_EN);
        set_in(1'b0, 2);
        tick();
        check("fault_clear_full", int'(full), 0);
        check("fault_err_sticky", int'(err),  ERR_EN);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/async_fifo_wr_ctl.md
Name: async_fifo_wr_ctl

Overview:
- Write-side control for the dual-clock FIFO. Lives entirely in the write clock domain (a_clk_i).
- Accepts push requests and generates the RAM write address and write enable.
- Maintains the binary write pointer. That pointer feeds the write-to-read pointer synchronizer.
- Consumes the read pointer after it has been synchronized back into this domain. From it, derives registered level, full and almost-full.

Parameters:
- ADDR_W, 4, RAM address width. Depth DEPTH = 2^ADDR_W. Pointers are ADDR_W+1 bits.
- AFULL_LVL, 2^ADDR_W-2, level at or above which afull_o asserts. Legal range 1..DEPTH.

Ports:
- rst_i  in  1  async reset, active high
- a_clk_i  in  1  write clock
- wr_i  in  1  push request, one word per cycle
- rd_ptr_i  in  ADDR_W+1  binary read pointer, already synchronized and registered into the a_clk_i domain
- wr_ptr_o  out  ADDR_W+1  binary write pointer, registered; drives the synchronizer input
- ram_addr_o  out  ADDR_W  RAM write address, = wr_ptr_o[ADDR_W-1:0]
- ram_we_o  out  1  RAM write enable, combinational
- full_o  out  1  FIFO full, registered
- afull_o  out  1  level >= AFULL_LVL, registered
- level_o  out  ADDR_W+1  words held (write-side view), registered
- err_o  out  1  sticky error; see Optional Feature

Behaviour:
- Reset (rst_i async, active high; clock a_clk_i):
  - wr_ptr_o=0, level_o=0, full_o=0, afull_o=0, err_o=0.
  - Reset mid-operation discards all state immediately. The RAM is not cleared.
  - The read side must be reset together with this block.
- Accept: acc = wr_i & ~full_o. ram_we_o = acc in the same cycle. ram_addr_o is the current wr_ptr_o.
- Pointer: on acc, wr_ptr_o <= wr_ptr_o + 1, modulo 2^(ADDR_W+1). The MSB is the wrap bit. There is no saturation: 2^(ADDR_W+1)-1 is followed by 0.
- Level:
  - nxt_ptr = wr_ptr_o + acc.
  - lvl_nxt = (nxt_ptr - rd_ptr_i), modulo 2^(ADDR_W+1).
  - Each clock: level_o <= lvl_nxt, full_o <= (lvl_nxt == DEPTH), afull_o <= (lvl_nxt >= AFULL_LVL).
- Timing:
  - full_o is valid in the same cycle as the wr_ptr_o it describes. No write can ever overrun.
  - A push in cycle N is reflected in level_o in cycle N+1.
  - A read-pointer change on rd_ptr_i in cycle N is reflected in cycle N+1.
- Simultaneous push and read-pointer advance: both terms enter lvl_nxt in the same cycle. Example: level 5, push plus rd_ptr_i+1 gives level 5.
- Push while full: ignored. No RAM write, no pointer change.
- Conservatism: rd_ptr_i lags the true read pointer by the synchronizer latency. level_o and full_o may therefore overstate occupancy, but never understate it. This is by design.
- rd_ptr_i is treated as opaque, except that lvl_nxt > DEPTH is a synchronizer fault condition. In that case full_o=1, since lvl_nxt != DEPTH is overridden to full, which blocks writes.
- Throughput: one word per cycle while not full. There are no bubbles at the wrap.

Optional Feature:
- Macro: ASYNC_FIFO_WR_ERR_EN.
- Defined: err_o sets on the a_clk_i edge following either condition, and stays set until rst_i:
  - wr_i & full_o (overflow attempt)
  - lvl_nxt > DEPTH (pointer fault)
- Undefined: err_o is tied to 0, and no error register is built.

Test Plan (ADDR_W=3, DEPTH=8, AFULL_LVL=6 unless stated):
- Fill:
  - Stimulus: rd_ptr_i=0, wr_i=1 for 9 cycles.
  - Required: ram_we_o high for 8 cycles with addresses 0..7. afull_o rises after the 6th push, full_o after the 8th. level_o=8, wr_ptr_o=8.
  - Required on the 9th cycle: ram_we_o=0 and wr_ptr_o stays at 8. With ASYNC_FIFO_WR_ERR_EN, err_o=1 next cycle.
- Drain release: from full, set rd_ptr_i=3 -> next cycle full_o=0, level_o=5, afull_o=0. A push is then accepted at ram_addr_o=0.
- Wrap: wr_i=1 continuously with rd_ptr_i tracking wr_ptr_o-2 -> wr_ptr_o steps 14, 15, 0, 1 with no stall. ram_addr_o follows 6, 7, 0, 1. level_o holds 2.
- Simultaneous: at level 5, push together with rd_ptr_i+1 -> level_o stays 5 and wr_ptr_o increments.
- Reset mid-fill: assert rst_i asynchronously at level 4 -> all outputs are 0 immediately, before the next edge. The first push after release writes address 0.
- Pointer fault: at wr_ptr_o=2, drive rd_ptr_i=12, giving lvl_nxt=6, then rd_ptr_i=9, giving lvl_nxt=9 -> full_o=1 and pushes are blocked. With the macro, err_o=1 and stays set.
